vending_ctrl: RTL and testbench
===============================

Name: vending_ctrl

Overview:
- Transaction controller for the vending front panel. It turns item-select, coin and cancel events into three 7-bit amounts: price_put, price_need and price_out.
- It sits directly upstream of the segment display driver, which consumes those three amounts unchanged. It also issues vend and beep strobes to the actuator and buzzer stages.
- All amounts are in units of 0.1 yuan, range 0..99, so 0.0..9.9 is shown on two digits.

Parameters:
- PRICE0, 25: price of item 0, in 0.1-yuan units.
- PRICE1, 35: price of item 1.
- PRICE2, 50: price of item 2.
- PRICE3, 85: price of item 3. Every price must be 1..89.
- HOLD_CYCLES, 150_000_000: clocks the DONE/REFUND result stays displayed (3 s at 50 MHz).
- TIMEOUT_CYCLES, 500_000_000: idle clocks in PAY before auto-refund.
- CNT_W, 29: width of the shared timer counter.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-high reset.
- sel_valid, input, 1: single-cycle item-select strobe.
- sel_item, input, 2: item index, sampled when sel_valid=1.
- coin_valid, input, 1: single-cycle coin-inserted strobe.
- coin_type, input, 1: 0 = 0.5 yuan (5 units), 1 = 1 yuan (10 units). Sampled when coin_valid=1.
- cancel, input, 1: single-cycle cancel strobe.
- price_put, output, 7: amount inserted so far.
- price_need, output, 7: price of the selected item.
- price_out, output, 7: change or refund amount.
- vend, output, 1: single-cycle dispense strobe.
- coin_reject, output, 1: single-cycle strobe; the coin just offered is returned unaccepted.
- beep_req, output, 1: single-cycle buzzer trigger.
- busy, output, 1: high in every state except IDLE.

Behaviour:
- All outputs are registered. On reset, or whenever rst is high: state=IDLE, all amounts 0, all strobes 0, timer 0.
- The state machine has four states: IDLE, PAY, DONE, REFUND. The state register and outputs update on the clock edge after the triggering strobe, so latency is 1 cycle.
- IDLE:
  - sel_valid: price_need <= PRICEn for n=sel_item, price_put <= 0, price_out <= 0, go to PAY, timer cleared.
  - coin_valid: coin_reject=1, no state change.
  - cancel: ignored.
- PAY:
  - Any accepted coin, or an accepted reselect, clears the timeout counter.
  - Let sum = price_put + coin value.
  - coin_valid without cancel, and sum >= price_need:
    - price_put <= sum, price_out <= sum - price_need.
    - vend=1 and beep_req=1 for one cycle.
    - Go to DONE, timer cleared.
  - coin_valid without cancel, and sum < price_need: price_put <= sum, stay in PAY.
  - cancel, with or without a coin in the same cycle:
    - price_out <= price_put, plus the coin value if a coin arrived in that cycle.
    - price_put and price_need hold (price_put does not add the same-cycle coin).
    - beep_req=1 for one cycle. Go to REFUND. Cancel has priority over completing the purchase.
  - sel_valid:
    - Accepted (price_need reloaded) only while price_put==0; otherwise ignored.
    - A select in the same cycle as a coin or cancel is ignored.
  - When the timer reaches TIMEOUT_CYCLES-1: treat it exactly as cancel. If price_put==0, go straight to IDLE with no beep.
- Width rule: prices ≤ 89 and price_put < price_need before every coin, so sum ≤ 98. No 7-bit overflow is possible, and no saturation logic is required.
- DONE / REFUND:
  - Amounts frozen; coin_valid → coin_reject=1; sel_valid and cancel are ignored.
  - Timer runs. At HOLD_CYCLES-1, go to IDLE and clear all three amounts to 0 on that same edge.
- Strobes (vend, coin_reject, beep_req) are high for exactly one cycle per event and are never asserted from IDLE except coin_reject.

Decomposition:
- Shared package vending_pkg:
  - state encoding (IDLE/PAY/DONE/REFUND);
  - COIN_05=5 and COIN_10=10;
  - AMT_W=7 and AMT_MAX=99, also used by the display driver.
- One sub-module, vend_timer: a CNT_W-bit counter with clear, enable and compare-to-terminal. It is used for both the hold and timeout intervals, with the terminal selected by state.

Test Plan (HOLD_CYCLES=20, TIMEOUT_CYCLES=50):
- Exact pay: select item1 (35), coins 10,10,10,5 → put=35, need=35, out=0; vend and beep pulse once. After 20 cycles all amounts are 0 and busy=0.
- Overpay: select item0 (25), coins 10,10,10 → put=30, out=5; vend once. A coin offered in DONE gives coin_reject=1 and the amounts are unchanged.
- Cancel with a same-cycle coin: select item3 (85), coins 10,10, then cancel together with a 5 coin → put=20, out=25, no vend; REFUND holds, then IDLE.
- Timeout: select item2 (50), coin 5, no activity → at cycle 50 out=5 and beep fires. A timeout with put=0 returns to IDLE silently.
- Reselect rules: select item0, then item3 → need=85. After coin 5, select item1 → need stays 85.
- Async reset mid-PAY: put=20, assert rst between clock edges → all outputs 0 immediately. After release, IDLE; a coin gives coin_reject=1.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared types and constants for the vending front panel.
// The amount constants are also consumed by the segment display driver.
package vending_pkg;

  // Controller state encoding.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PAY    = 2'd1,
    ST_DONE   = 2'd2,
    ST_REFUND = 2'd3
  } state_e;

  // Amounts are in 0.1-yuan units, shown on two digits (0.0 .. 9.9).
  localparam int                AMT_W   = 7;
  localparam logic [AMT_W-1:0] AMT_MAX = 7'd99;

  // Coin denominations in 0.1-yuan units.
  localparam logic [AMT_W-1:0] COIN_05 = 7'd5;
  localparam logic [AMT_W-1:0] COIN_10 = 7'd10;

  // Value of a coin given its type bit (0 = 0.5 yuan, 1 = 1 yuan).
  function automatic logic [AMT_W-1:0] coin_value(input logic coin_type);
    logic [AMT_W-1:0] v;
    if (coin_type) begin
      v = COIN_10;
    end else begin
      v = COIN_05;
    end
    return v;
  endfunction

  // Convert an integer price parameter to an amount, clipped to the display range.
  function automatic logic [AMT_W-1:0] to_amt(input int p);
    logic [AMT_W-1:0] a;
    if (p > int'(AMT_MAX)) begin
      a = AMT_MAX;
    end else if (p < 0) begin
      a = '0;
    end else begin
      a = AMT_W'(p);
    end
    return a;
  endfunction

endpackage

// File: rtl/vending_ctrl_timer.sv
// Shared interval timer: counts enabled cycles, clears synchronously and
// flags when the count equals the selected terminal value.
module vend_timer #(
  parameter int CNT_W = 29
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] term_i,
  output logic             hit_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins over enable, otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Terminal match only counts while the timer is running.
  assign hit_o = en_i && (cnt_q == term_i);

endmodule

// File: rtl/vending_ctrl.sv
// Vending front-panel transaction controller. Turns select, coin and cancel
// strobes into the inserted / needed / change amounts for the display and
// raises vend, coin-reject and beep strobes. All outputs are registered.
module vending_ctrl
  import vending_pkg::*;
#(
  parameter int PRICE0         = 25,
  parameter int PRICE1         = 35,
  parameter int PRICE2         = 50,
  parameter int PRICE3         = 85,
  parameter int HOLD_CYCLES    = 150_000_000,
  parameter int TIMEOUT_CYCLES = 500_000_000,
  parameter int CNT_W          = 29
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel_valid,
  input  logic [1:0]       sel_item,
  input  logic             coin_valid,
  input  logic             coin_type,
  input  logic             cancel,
  output logic [AMT_W-1:0] price_put,
  output logic [AMT_W-1:0] price_need,
  output logic [AMT_W-1:0] price_out,
  output logic             vend,
  output logic             coin_reject,
  output logic             beep_req,
  output logic             busy
);

  localparam logic [AMT_W-1:0] PRICE0_A = to_amt(PRICE0);
  localparam logic [AMT_W-1:0] PRICE1_A = to_amt(PRICE1);
  localparam logic [AMT_W-1:0] PRICE2_A = to_amt(PRICE2);
  localparam logic [AMT_W-1:0] PRICE3_A = to_amt(PRICE3);

  localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_TERM  = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [AMT_W-1:0] put_q, put_d;
  logic [AMT_W-1:0] need_q, need_d;
  logic [AMT_W-1:0] out_q, out_d;
  logic             vend_q, vend_d;
  logic             rej_q, rej_d;
  logic             beep_q, beep_d;
  logic             busy_q, busy_d;

  logic [AMT_W-1:0] price_sel_s;
  logic [AMT_W-1:0] coin_amt_s;
  logic [AMT_W-1:0] coin_in_s;
  logic [AMT_W-1:0] sum_s;
  logic             quiet_tmo_s;
  logic             tmr_clr_s;
  logic             tmr_en_s;
  logic [CNT_W-1:0] tmr_term_s;
  logic             tmr_hit_s;

  // Price lookup for the item index on the select strobe.
  always_comb begin
    price_sel_s = PRICE0_A;
    case (sel_item)
      2'd0:    price_sel_s = PRICE0_A;
      2'd1:    price_sel_s = PRICE1_A;
      2'd2:    price_sel_s = PRICE2_A;
      2'd3:    price_sel_s = PRICE3_A;
      default: price_sel_s = PRICE0_A;
    endcase
  end

  // Coin arithmetic; prices below 90 keep the running sum within 7 bits.
  always_comb begin
    coin_amt_s = coin_value(coin_type);
    sum_s      = put_q + coin_amt_s;
    if (coin_valid) begin
      coin_in_s = coin_amt_s;
    end else begin
      coin_in_s = '0;
    end
    // A timeout with nothing inserted and no coin arriving returns silently.
    quiet_tmo_s = (put_q == '0) && !coin_valid;
  end

  // Timer terminal follows the state: timeout while paying, hold otherwise.
  always_comb begin
    tmr_en_s = (state_q != ST_IDLE);
    if (state_q == ST_PAY) begin
      tmr_term_s = TMO_TERM;
    end else begin
      tmr_term_s = HOLD_TERM;
    end
  end

  vend_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (tmr_clr_s),
    .en_i   (tmr_en_s),
    .term_i (tmr_term_s),
    .hit_o  (tmr_hit_s)
  );

  // Next-state and next-output logic for the transaction FSM.
  always_comb begin
    state_d   = state_q;
    put_d     = put_q;
    need_d    = need_q;
    out_d     = out_q;
    vend_d    = 1'b0;
    rej_d     = 1'b0;
    beep_d    = 1'b0;
    tmr_clr_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tmr_clr_s = 1'b1;
        rej_d     = coin_valid;
        if (sel_valid) begin
          need_d  = price_sel_s;
          put_d   = '0;
          out_d   = '0;
          state_d = ST_PAY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PAY: begin
        if (cancel || (tmr_hit_s && !quiet_tmo_s)) begin
          // Cancel (or timeout) beats completing the purchase; a same-cycle
          // coin goes straight into the refund, not into price_put.
          out_d     = put_q + coin_in_s;
          beep_d    = 1'b1;
          state_d   = ST_REFUND;
          tmr_clr_s = 1'b1;
        end else if (tmr_hit_s) begin
          put_d     = '0;
          need_d    = '0;
          out_d     = '0;
          state_d   = ST_IDLE;
          tmr_clr_s = 1'b1;
        end else if (coin_valid) begin
          put_d     = sum_s;
          tmr_clr_s = 1'b1;
          if (sum_s >= need_q) begin
            out_d   = sum_s - need_q;
            vend_d  = 1'b1;
            beep_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_PAY;
          end
        end else if (sel_valid && (put_q == '0)) begin
          need_d    = price_sel_s;
          tmr_clr_s = 1'b1;
        end else begin
          state_d = ST_PAY;
        end
      end
      ST_DONE, ST_REFUND: begin
        rej_d = coin_valid;
        if (tmr_hit_s) begin
          put_d     = '0;
          need_d    = '0;
          out_d     = '0;
          state_d   = ST_IDLE;
          tmr_clr_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        put_d     = '0;
        need_d    = '0;
        out_d     = '0;
        state_d   = ST_IDLE;
        tmr_clr_s = 1'b1;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      put_q   <= '0;
      need_q  <= '0;
      out_q   <= '0;
      vend_q  <= 1'b0;
      rej_q   <= 1'b0;
      beep_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      put_q   <= put_d;
      need_q  <= need_d;
      out_q   <= out_d;
      vend_q  <= vend_d;
      rej_q   <= rej_d;
      beep_q  <= beep_d;
      busy_q  <= busy_d;
    end
  end

  assign price_put   = put_q;
  assign price_need  = need_q;
  assign price_out   = out_q;
  assign vend        = vend_q;
  assign coin_reject = rej_q;
  assign beep_req    = beep_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_vending_ctrl.sv
// Bench for vending_ctrl: directed vector table, hand-written timing corner
// cases and randomized traffic against a behavioural reference model.
module tb_vending_ctrl;

  localparam int HOLD = 20;
  localparam int TMO  = 50;

  // Reference model modes: waiting, collecting money, showing a result.
  localparam int M_IDLE = 0;
  localparam int M_PAY  = 1;
  localparam int M_HOLD = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel_valid, coin_valid, coin_type, cancel;
  logic [1:0] sel_item;
  logic [6:0] price_put, price_need, price_out;
  logic       vend, coin_reject, beep_req, busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vending_ctrl #(
    .PRICE0(25), .PRICE1(35), .PRICE2(50), .PRICE3(85),
    .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO), .CNT_W(29)
  ) dut (
    .clk(clk), .rst(rst),
    .sel_valid(sel_valid), .sel_item(sel_item),
    .coin_valid(coin_valid), .coin_type(coin_type), .cancel(cancel),
    .price_put(price_put), .price_need(price_need), .price_out(price_out),
    .vend(vend), .coin_reject(coin_reject), .beep_req(beep_req), .busy(busy)
  );

  // ---------------- reference model ----------------
  int prices [4] = '{25, 35, 50, 85};
  int m_mode, m_put, m_need, m_out, m_left;
  bit m_vend, m_rej, m_beep;

  task automatic model_reset();
    m_mode = M_IDLE; m_put = 0; m_need = 0; m_out = 0; m_left = 0;
    m_vend = 0; m_rej = 0; m_beep = 0;
  endtask

  // One clock edge of the specified behaviour. m_left counts edges remaining
  // until the current hold or timeout interval expires.
  task automatic model_edge(bit s, int it, bit c, bit ct, bit x);
    int cv;
    bit expired;
    cv = c ? (ct ? 10 : 5) : 0;
    expired = (m_left == 1);
    m_vend = 0; m_rej = 0; m_beep = 0;
    if (m_mode == M_IDLE) begin
      if (c) m_rej = 1;
      if (s) begin
        m_need = prices[it]; m_put = 0; m_out = 0; m_mode = M_PAY; m_left = TMO;
      end
    end else if (m_mode == M_PAY) begin
      if (x || (expired && !(m_put == 0 && !c))) begin
        m_out = m_put + cv; m_beep = 1; m_mode = M_HOLD; m_left = HOLD;
      end else if (expired) begin
        m_put = 0; m_need = 0; m_out = 0; m_mode = M_IDLE;
      end else if (c) begin
        m_put = m_put + cv; m_left = TMO;
        if (m_put >= m_need) begin
          m_out = m_put - m_need; m_vend = 1; m_beep = 1; m_mode = M_HOLD; m_left = HOLD;
        end
      end else if (s && m_put == 0) begin
        m_need = prices[it]; m_left = TMO;
      end else begin
        m_left = m_left - 1;
      end
    end else begin
      if (c) m_rej = 1;
      if (expired) begin
        m_put = 0; m_need = 0; m_out = 0; m_mode = M_IDLE;
      end else begin
        m_left = m_left - 1;
      end
    end
  endtask

  // ---------------- helpers ----------------
  function automatic logic [24:0] pk(int put, int need, int out, bit v, bit r, bit b, bit y);
    return {7'(put), 7'(need), 7'(out), v, r, b, y};
  endfunction

  task automatic check(string name, logic [24:0] exp);
    logic [24:0] act;
    act = {price_put, price_need, price_out, vend, coin_reject, beep_req, busy};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got put=%0d need=%0d out=%0d vend/rej/beep/busy=%b, expected put=%0d need=%0d out=%0d vend/rej/beep/busy=%b",
               name, act[24:18], act[17:11], act[10:4], act[3:0],
               exp[24:18], exp[17:11], exp[10:4], exp[3:0]);
    end
  endtask

  task automatic check_model(string name);
    check(name, pk(m_put, m_need, m_out, m_vend, m_rej, m_beep, m_mode != M_IDLE));
  endtask

  // Apply one cycle of inputs, let the edge happen, then sample after it.
  task automatic step(bit s, logic [1:0] it, bit c, bit ct, bit x);
    sel_valid = s; sel_item = it; coin_valid = c; coin_type = ct; cancel = x;
    @(posedge clk);
    #1;
    model_edge(s, int'(it), c, ct, x);
    sel_valid = 1'b0; coin_valid = 1'b0; cancel = 1'b0;
  endtask

  task automatic idle_steps(int n);
    for (int k = 0; k < n; k++) step(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Run until the model is back in IDLE, checking every cycle; bounded.
  task automatic drain(string name);
    for (int k = 0; k < HOLD + 5 && m_mode != M_IDLE; k++) begin
      step(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      check_model(name);
    end
    check({name, "_idle"}, pk(0, 0, 0, 0, 0, 0, 0));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          s;
    logic [1:0]  it;
    bit          c;
    bit          ct;
    bit          x;
    logic [24:0] exp;
  } vec_t;

  vec_t tbl [27];

  task automatic run_tbl(string name, int lo, int hi);
    for (int i = lo; i <= hi; i++) begin
      step(tbl[i].s, tbl[i].it, tbl[i].c, tbl[i].ct, tbl[i].x);
      check($sformatf("%s[%0d]", name, i), tbl[i].exp);
    end
  endtask

  initial begin
    // exact pay: coin/cancel in IDLE, item1, 10+10+10+5
    tbl[0]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, pk(0, 0, 0, 0, 1, 0, 0)};
    tbl[1]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, pk(0, 0, 0, 0, 0, 0, 0)};
    tbl[2]  = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b0, pk(0, 35, 0, 0, 0, 0, 1)};
    tbl[3]  = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b0, pk(10, 35, 0, 0, 0, 0, 1)};
    tbl[4]  = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b0, pk(20, 35, 0, 0, 0, 0, 1)};
    tbl[5]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, pk(20, 35, 0, 0, 0, 0, 1)};
    tbl[6]  = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b0, pk(30, 35, 0, 0, 0, 0, 1)};
    tbl[7]  = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b0, pk(30, 35, 0, 0, 0, 0, 1)};
    tbl[8]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, pk(35, 35, 0, 1, 0, 1, 1)};
    tbl[9]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, pk(35, 35, 0, 0, 0, 0, 1)};
    tbl[10] = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b0, pk(35, 35, 0, 0, 1, 0, 1)};
    tbl[11] = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b1, pk(35, 35, 0, 0, 0, 0, 1)};
    // overpay: item0, 10+10+10, coin offered in DONE
    tbl[12] = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b0, pk(0, 25, 0, 0, 0, 0, 1)};
    tbl[13] = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b0, pk(10, 25, 0, 0, 0, 0, 1)};
    tbl[14] = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b0, pk(20, 25, 0, 0, 0, 0, 1)};
    tbl[15] = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b0, pk(30, 25, 5, 1, 0, 1, 1)};
    tbl[16] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, pk(30, 25, 5, 0, 1, 0, 1)};
    // cancel with same-cycle coin: item3, 10+10, cancel+5
    tbl[17] = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b0, pk(0, 85, 0, 0, 0, 0, 1)};
    tbl[18] = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b0, pk(10, 85, 0, 0, 0, 0, 1)};
    tbl[19] = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b0, pk(20, 85, 0, 0, 0, 0, 1)};
    tbl[20] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, pk(20, 85, 25, 0, 0, 1, 1)};
    tbl[21] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, pk(20, 85, 25, 0, 0, 0, 1)};
    // reselect rules: item0 then item3 accepted; after a coin, item1 ignored
    tbl[22] = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b0, pk(0, 25, 0, 0, 0, 0, 1)};
    tbl[23] = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b0, pk(0, 85, 0, 0, 0, 0, 1)};
    tbl[24] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, pk(5, 85, 0, 0, 0, 0, 1)};
    tbl[25] = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b0, pk(5, 85, 0, 0, 0, 0, 1)};
    tbl[26] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, pk(5, 85, 5, 0, 0, 1, 1)};

    rst = 1'b1; sel_valid = 1'b0; sel_item = 2'd0;
    coin_valid = 1'b0; coin_type = 1'b0; cancel = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset", pk(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;

    // exact pay, then hold boundary: DONE entered on row 8, 3 rows in DONE
    run_tbl("exact", 0, 11);
    idle_steps(16);
    check("hold_last", pk(35, 35, 0, 0, 0, 0, 1));
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    check("hold_exit", pk(0, 0, 0, 0, 0, 0, 0));

    run_tbl("overpay", 12, 16);
    drain("overpay_drain");
    run_tbl("cancel", 17, 21);
    drain("cancel_drain");
    run_tbl("resel", 22, 26);
    drain("resel_drain");

    // timeout with money inserted: fires on the 50th quiet edge
    step(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    step(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    idle_steps(TMO - 1);
    check("tmo_before", pk(5, 50, 0, 0, 0, 0, 1));
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    check("tmo_fire", pk(5, 50, 5, 0, 0, 1, 1));
    drain("tmo_drain");

    // timeout with nothing inserted: silent return to IDLE
    step(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    idle_steps(TMO - 1);
    check("tmo0_before", pk(0, 25, 0, 0, 0, 0, 1));
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    check("tmo0_fire", pk(0, 0, 0, 0, 0, 0, 0));

    // asynchronous reset between edges while paying
    step(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
    check("pre_rst", pk(20, 25, 0, 0, 0, 0, 1));
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_rst", pk(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
    check("post_rst_coin", pk(0, 0, 0, 0, 1, 0, 0));

    // randomized traffic, alternating busy and quiet phases
    for (int i = 0; i < 4000; i++) begin
      bit quiet;
      bit s, c, ct, x;
      logic [1:0] it;
      quiet = ((i / 400) % 2) == 1;
      s  = ($urandom_range(7) == 0);
      it = 2'($urandom_range(3));
      c  = quiet ? ($urandom_range(59) == 0) : ($urandom_range(2) == 0);
      ct = 1'($urandom_range(1));
      x  = quiet ? ($urandom_range(199) == 0) : ($urandom_range(19) == 0);
      step(s, it, c, ct, x);
      check_model("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
